// File: rtl/ppu_pkg.sv
// Shared constants, pipeline payload types and the NES RGB colour table for the PPU pixel path.
package ppu_pkg;

    localparam int unsigned PAL_ENTRIES = 32;
    localparam int unsigned NES_COLORS  = 64;
    localparam int unsigned LATENCY     = 3;
    localparam int unsigned PAL_AW      = 5;
    localparam int unsigned COLOR_W     = 6;
    localparam int unsigned RGB_W       = 24;

    // Stage-1 payload: resolved palette index plus the grayscale bit travelling with it.
    typedef struct packed {
        logic [PAL_AW-1:0] pal_idx;
        logic              gray;
    } s1_pix_t;

    // NES master palette as RGB888; unused slots (0x0D-0x0F, 0x1D-0x1F, 0x2E-0x2F, 0x3E-0x3F) are black.
    localparam logic [RGB_W-1:0] NES_RGB [NES_COLORS] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Sprite backdrop slots (low two bits zero) alias the matching background slot.
    function automatic logic [PAL_AW-1:0] pal_mirror(input logic [PAL_AW-1:0] addr);
        return (addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;
    endfunction

endpackage

// File: rtl/ppu_palette_rom.sv
// Registered 64-entry NES colour index to RGB888 lookup; emits black when not enabled.
module ppu_palette_rom
    import ppu_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_ce,
    input  logic               i_en,
    input  logic [COLOR_W-1:0] i_idx,
    output logic [RGB_W-1:0]   o_rgb
);

    // Colour lookup register; blanks the output for non-visible slots.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_rgb <= '0;
        end else if (i_ce) begin
            o_rgb <= i_en ? NES_RGB[i_idx] : '0;
        end
    end

endmodule

// File: rtl/ppu_pixel_mux.sv
// Final PPU pixel stage: bg/sprite priority, palette RAM, grayscale, RGB lookup and sprite-0 hit.
module ppu_pixel_mux #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_active,
    input  logic [7:0]  i_x,
    input  logic [3:0]  i_bg,
    input  logic [4:0]  i_spr,
    input  logic        i_spr0,
    input  logic        i_bg_en,
    input  logic        i_spr_en,
    input  logic        i_bg_clip,
    input  logic        i_spr_clip,
    input  logic        i_gray,
    input  logic        i_exiting_vblank,
    input  logic        i_pal_we,
    input  logic [4:0]  i_pal_addr,
    input  logic [5:0]  i_pal_wdata,
    output logic [5:0]  o_pal_rdata,
    output logic [23:0] o_pixel,
    output logic        o_valid,
    output logic        o_spr0_hit
);

    import ppu_pkg::*;

    logic [LATENCY-1:0]  vld_q;
    s1_pix_t             s1_q;
    logic [COLOR_W-1:0]  s2_color_q;
    logic [COLOR_W-1:0]  pal_ram [PAL_ENTRIES];

    logic                in_clip_c;
    logic                bg_vis_c;
    logic                spr_vis_c;
    logic                hit_c;
    logic [PAL_AW-1:0]   idx_c;

    // Clip/enable masking, opacity and priority resolve to a 5-bit palette index.
    always_comb begin
        in_clip_c = (i_x < 8'd8);
        bg_vis_c  = i_bg_en  && !(i_bg_clip  && in_clip_c) && (i_bg[1:0]  != 2'b00);
        spr_vis_c = i_spr_en && !(i_spr_clip && in_clip_c) && (i_spr[1:0] != 2'b00);
        idx_c     = '0;
        if (bg_vis_c && spr_vis_c) begin
            idx_c = i_spr[4] ? {1'b0, i_bg} : {1'b1, i_spr[3:0]};
        end else if (bg_vis_c) begin
            idx_c = {1'b0, i_bg};
        end else if (spr_vis_c) begin
            idx_c = {1'b1, i_spr[3:0]};
        end
        hit_c = i_active && bg_vis_c && spr_vis_c && i_spr0 && (i_x != 8'd255);
    end

    // Visible-pixel marker travelling alongside the data stages.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            vld_q <= '0;
        end else if (i_ce) begin
            vld_q <= {vld_q[LATENCY-2:0], i_active};
        end
    end

    // S1: resolved palette index.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            s1_q <= '0;
        end else if (i_ce) begin
            s1_q.pal_idx <= idx_c;
            s1_q.gray    <= i_gray;
        end
    end

    // S2: palette RAM read (pre-write contents) with grayscale masking.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            s2_color_q <= '0;
        end else if (i_ce) begin
            s2_color_q <= pal_ram[pal_mirror(s1_q.pal_idx)] & (s1_q.gray ? 6'h30 : 6'h3F);
        end
    end

    // S3: colour index to RGB888.
    ppu_palette_rom u_rom (
        .clk   (clk),
        .i_rst (i_rst),
        .i_ce  (i_ce),
        .i_en  (vld_q[LATENCY-2]),
        .i_idx (s2_color_q),
        .o_rgb (o_pixel)
    );

    assign o_valid = vld_q[LATENCY-1];

    // Palette RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_ce && i_pal_we) begin
            pal_ram[pal_mirror(i_pal_addr)] <= i_pal_wdata;
        end
    end

    // CPU read port, write-first on a same-cycle write.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_pal_rdata <= '0;
        end else if (i_ce) begin
            o_pal_rdata <= i_pal_we ? i_pal_wdata : pal_ram[pal_mirror(i_pal_addr)];
        end
    end

    // Sticky sprite-0 hit; leaving vblank clears and overrides a same-cycle set.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_spr0_hit <= 1'b0;
        end else if (i_ce) begin
            if (i_exiting_vblank) begin
                o_spr0_hit <= 1'b0;
            end else if (hit_c) begin
                o_spr0_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Randomized and directed bench for ppu_pixel_mux against a behavioural model.
module tb_ppu_pixel_mux;

    logic        clk = 1'b0;
    logic        i_rst, i_ce, i_active;
    logic [7:0]  i_x;
    logic [3:0]  i_bg;
    logic [4:0]  i_spr;
    logic        i_spr0, i_bg_en, i_spr_en, i_bg_clip, i_spr_clip, i_gray;
    logic        i_exiting_vblank, i_pal_we;
    logic [4:0]  i_pal_addr;
    logic [5:0]  i_pal_wdata;
    logic [5:0]  o_pal_rdata;
    logic [23:0] o_pixel;
    logic        o_valid, o_spr0_hit;

    int errors = 0;
    int checks = 0;

    // Reference NES colours, kept independently of the design package.
    logic [23:0] rom_m [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Model state
    int          pal_m [32];
    bit          pend_v, res_v, exp_valid, exp_hit;
    int          pend_idx;
    bit          pend_gray;
    logic [23:0] res_rgb, exp_pix;
    int          exp_rdata;

    ppu_pixel_mux #(.LATENCY(3)) dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_ce             (i_ce),
        .i_active         (i_active),
        .i_x              (i_x),
        .i_bg             (i_bg),
        .i_spr            (i_spr),
        .i_spr0           (i_spr0),
        .i_bg_en          (i_bg_en),
        .i_spr_en         (i_spr_en),
        .i_bg_clip        (i_bg_clip),
        .i_spr_clip       (i_spr_clip),
        .i_gray           (i_gray),
        .i_exiting_vblank (i_exiting_vblank),
        .i_pal_we         (i_pal_we),
        .i_pal_addr       (i_pal_addr),
        .i_pal_wdata      (i_pal_wdata),
        .o_pal_rdata      (o_pal_rdata),
        .o_pixel          (o_pixel),
        .o_valid          (o_valid),
        .o_spr0_hit       (o_spr0_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mir(input int a);
        return (a % 4 == 0) ? (a % 16) : a;
    endfunction

    // One clock of the behavioural model, using the inputs that were present at the edge.
    task automatic model_update();
        bit bg_ok, spr_ok, clipzone;
        int idx, col;
        if (i_rst) begin
            pend_v = 0; res_v = 0; res_rgb = '0;
            exp_valid = 0; exp_pix = '0; exp_hit = 0; exp_rdata = 0;
        end else if (i_ce) begin
            exp_valid = res_v;
            exp_pix   = res_v ? res_rgb : 24'h0;
            col       = pal_m[mir(pend_idx)];
            if (pend_gray) col = col & 'h30;
            res_v     = pend_v;
            res_rgb   = rom_m[col];
            exp_rdata = i_pal_we ? int'(i_pal_wdata) : pal_m[mir(int'(i_pal_addr))];
            if (i_pal_we) pal_m[mir(int'(i_pal_addr))] = int'(i_pal_wdata);
            clipzone = (i_x < 8);
            bg_ok    = i_bg_en  && !(i_bg_clip  && clipzone) && (i_bg % 4 != 0);
            spr_ok   = i_spr_en && !(i_spr_clip && clipzone) && (i_spr % 4 != 0);
            if (!bg_ok && !spr_ok)      idx = 0;
            else if (bg_ok && !spr_ok)  idx = int'(i_bg);
            else if (!bg_ok && spr_ok)  idx = 16 + (i_spr % 16);
            else                        idx = i_spr[4] ? int'(i_bg) : 16 + (i_spr % 16);
            if (i_exiting_vblank) exp_hit = 0;
            else if (i_active && bg_ok && spr_ok && i_spr0 && i_x != 255) exp_hit = 1;
            pend_v    = i_active;
            pend_idx  = idx;
            pend_gray = i_gray;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        check("valid", 32'(o_valid), 32'(exp_valid));
        check("pixel", 32'(o_pixel), 32'(exp_pix));
        check("hit",   32'(o_spr0_hit), 32'(exp_hit));
        check("rdata", 32'(o_pal_rdata), 32'(exp_rdata));
    endtask

    task automatic pal_write(input int addr, input int data);
        i_pal_we = 1'b1; i_pal_addr = 5'(addr); i_pal_wdata = 6'(data);
        tick();
        i_pal_we = 1'b0;
    endtask

    // Drive one visible pixel, then idle until it reaches the output.
    task automatic px(input int x, input int bg, input int spr, input bit spr0);
        i_active = 1'b1; i_x = 8'(x); i_bg = 4'(bg); i_spr = 5'(spr); i_spr0 = spr0;
        tick();
        i_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        i_rst = 1'b1; i_ce = 1'b1; i_active = 1'b0; i_x = '0; i_bg = '0; i_spr = '0;
        i_spr0 = 1'b0; i_bg_en = 1'b1; i_spr_en = 1'b1; i_bg_clip = 1'b0; i_spr_clip = 1'b0;
        i_gray = 1'b0; i_exiting_vblank = 1'b0; i_pal_we = 1'b0; i_pal_addr = '0; i_pal_wdata = '0;
        for (int i = 0; i < 32; i++) pal_m[i] = 0;
        pend_v = 0; res_v = 0; pend_idx = 0; pend_gray = 0; res_rgb = '0;
        exp_valid = 0; exp_pix = '0; exp_hit = 0; exp_rdata = 0;

        tick();
        tick();
        check("rst_pixel", 32'(o_pixel), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_hit",   32'(o_spr0_hit), 32'h0);
        check("rst_rdata", 32'(o_pal_rdata), 32'h0);
        i_rst = 1'b0;

        for (int i = 0; i < 32; i++) pal_write(i, int'($urandom_range(0, 63)));

        // Priority between opaque layers
        pal_write('h05, 'h16);
        pal_write('h11, 'h2A);
        px(100, 'h5, 'h01, 1'b0);
        check("prio_spr_front", 32'(o_pixel), 32'h58D854);
        px(100, 'h5, 'h11, 1'b0);
        check("prio_spr_behind", 32'(o_pixel), 32'hF83800);

        // Mirroring of sprite backdrop onto universal background
        pal_write('h10, 'h21);
        i_pal_addr = 5'h00;
        tick();
        check("mirror_rdata", 32'(o_pal_rdata), 32'h21);
        px(40, 'h0, 'h00, 1'b0);
        check("backdrop_pixel", 32'(o_pixel), 32'h3CBCFC);

        // Clipping and sprite-0 hit
        i_bg_clip = 1'b1;
        px(5, 'h1, 'h01, 1'b1);
        check("clip_hit", 32'(o_spr0_hit), 32'h0);
        check("clip_pixel", 32'(o_pixel), 32'h58D854);
        i_active = 1'b1; i_x = 8'd8;
        tick();
        check("hit_x8", 32'(o_spr0_hit), 32'h1);
        i_active = 1'b0;
        i_exiting_vblank = 1'b1;
        tick();
        check("hit_cleared", 32'(o_spr0_hit), 32'h0);
        i_exiting_vblank = 1'b0;
        i_bg_clip = 1'b0;
        px(255, 'h1, 'h01, 1'b1);
        check("hit_x255", 32'(o_spr0_hit), 32'h0);

        // Set and clear collide: clear wins
        i_exiting_vblank = 1'b1;
        px(50, 'h1, 'h01, 1'b1);
        check("hit_collision", 32'(o_spr0_hit), 32'h0);
        i_exiting_vblank = 1'b0;
        i_spr0 = 1'b0;

        // Grayscale
        pal_write('h01, 'h2C);
        i_gray = 1'b1;
        px(60, 'h1, 'h00, 1'b0);
        check("gray_pixel", 32'(o_pixel), 32'hF8F8F8);
        i_gray = 1'b0;

        // Reset in the middle of a pixel stream, then clock-enable freeze
        i_active = 1'b1; i_bg = 4'h6; i_x = 8'd120;
        for (int i = 0; i < 5; i++) tick();
        i_rst = 1'b1;
        tick();
        check("midrst_valid", 32'(o_valid), 32'h0);
        check("midrst_pixel", 32'(o_pixel), 32'h0);
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        i_ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_active = 1'($urandom); i_bg = 4'($urandom); i_pal_we = 1'b1;
            i_pal_addr = 5'($urandom); i_pal_wdata = 6'($urandom); i_exiting_vblank = 1'b1;
            tick();
        end
        i_ce = 1'b1; i_pal_we = 1'b0; i_exiting_vblank = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            i_rst       = ($urandom_range(0, 149) == 0);
            i_ce        = ($urandom_range(0, 7) != 0);
            i_active    = ($urandom_range(0, 3) != 0);
            i_x         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) :
                          ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom);
            i_bg        = 4'($urandom);
            i_spr       = 5'($urandom);
            i_spr0      = 1'($urandom);
            i_bg_en     = ($urandom_range(0, 7) != 0);
            i_spr_en    = ($urandom_range(0, 7) != 0);
            i_bg_clip   = 1'($urandom);
            i_spr_clip  = 1'($urandom);
            i_gray      = ($urandom_range(0, 7) == 0);
            i_exiting_vblank = ($urandom_range(0, 15) == 0);
            i_pal_we    = !i_rst && ($urandom_range(0, 3) == 0);
            i_pal_addr  = 5'($urandom);
            i_pal_wdata = 6'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppu_pixel_mux.md
# ppu_pixel_mux

Final pixel stage of the PPU. Each active pixel cycle it takes the background pixel and the sprite pixel from the 8-sprite set and performs the priority decision. It maps the result through the 32-entry palette RAM and the 64-colour NES RGB ROM, and emits a 24-bit RGB pixel to the video output. It also owns the CPU-visible palette RAM ($3F00–$3F1F) and the sprite-0 hit flag.

## Interface
Parameters:
- `LATENCY`, 3: pixel pipeline depth in cycles. Fixed; exposed for bench alignment only.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_ce`  in  1  clock enable; all state advances only when high.
- `i_active`  in  1  current cycle carries a visible pixel.
- `i_x`  in  8  pixel column, 0–255.
- `i_bg`  in  4  background pixel: [3:2] palette, [1:0] colour.
- `i_spr`  in  5  sprite bits: [4] behind-bg priority, [3:2] palette, [1:0] colour.
- `i_spr0`  in  1  sprite 0 supplied the opaque sprite pixel.
- `i_bg_en`, `i_spr_en`  in  1 each  PPUMASK bg/sprite enable.
- `i_bg_clip`, `i_spr_clip`  in  1 each  high = hide bg/sprites in columns 0–7.
- `i_gray`  in  1  PPUMASK grayscale.
- `i_exiting_vblank`  in  1  clears the sprite-0 hit flag.
- `i_pal_we`  in  1  CPU palette write strobe.
- `i_pal_addr`  in  5  CPU palette address.
- `i_pal_wdata`  in  6  CPU write data.
- `o_pal_rdata`  out  6  CPU read data, registered.
- `o_pixel`  out  24  RGB888 output.
- `o_valid`  out  1  `o_pixel` is a visible pixel.
- `o_spr0_hit`  out  1  sticky sprite-0 hit flag.

## Operation
- **Clipping.** Clipping applies when `i_x < 8` and the matching clip bit is set. A clipped or disabled layer is forced transparent.
- **Opacity.** The background is opaque when `bg[1:0] != 0`. The sprite is opaque when `spr[1:0] != 0`.
- **Priority.** Evaluate in order:
  - Both layers transparent: palette index 0.
  - Only bg opaque: `{0, bg}`.
  - Only sprite opaque: `{1, spr[3:0]}`.
  - Both opaque: sprite if `spr[4] == 0`, else bg.
- **Palette mirroring.** Applies to both CPU and pixel accesses. Any address with `[1:0] == 0` maps to `{0, addr[3:0]}`. So 0x10, 0x14, 0x18 and 0x1C alias 0x00, 0x04, 0x08 and 0x0C.
- **Palette RAM contents.** The RAM is 32×6 and is not cleared by reset.
- **Grayscale.** When `i_gray` is set, the colour index is ANDed with 0x30 before the ROM lookup.
- **RGB ROM.** 64×24, contents defined in `ppu_pkg`. Entries 0x0D–0x0F, 0x1D–0x1F, 0x2E–0x2F and 0x3E–0x3F are 24'h000000.
- **Output when not valid.** `o_pixel` = 24'h000000 whenever `o_valid == 0`.
- **Sprite-0 hit.** The flag sets when all of the following hold:
  - `i_active`
  - background opaque (after clip/enable)
  - sprite opaque (after clip/enable)
  - `i_spr0`
  - `i_x != 255`
- **Sprite-0 clear.** `i_exiting_vblank` clears the flag. If set and clear occur in the same cycle, clear wins.
- **CPU writes.** `i_pal_we` writes `i_pal_wdata` at the mirrored address.
- **CPU reads.** `o_pal_rdata` updates every `i_ce` cycle from the mirrored `i_pal_addr`. A same-cycle write returns the new data (write-first).

## Timing
- **Reset values.** `o_pixel` = 0, `o_valid` = 0, `o_spr0_hit` = 0, `o_pal_rdata` = 0. All pipeline valid bits are cleared.
- **Pipeline stages.**
  - S1: clip, priority and palette index registered.
  - S2: palette RAM read, grayscale applied, registered.
  - S3: ROM lookup registered.
- **Pixel latency.** `o_valid`/`o_pixel` follow `i_active` by exactly 3 `i_ce` cycles.
- **Write/read ordering.** A palette write in cycle N affects pixels whose S2 read occurs in cycle N+1 or later. A pixel in S2 during cycle N sees the old value.
- **Sprite-0 hit latency.** `o_spr0_hit` rises 1 cycle after the qualifying input pixel. It does not wait for the pixel pipeline.
- **Clock enable.** With `i_ce` low, all registers hold, including `o_valid`.
- **Reset mid-line.** The pipeline flushes and `o_valid` is low for the next 3 cycles after release.

## Structure
- **`ppu_pkg`:**
  - `PAL_ENTRIES` = 32
  - `NES_COLORS` = 64
  - `LATENCY` = 3
  - the 64-entry RGB888 constant table
  - the mirror-address function
- **`ppu_palette_rom` sub-module:** 6-bit index in, registered 24-bit RGB out; instantiated once for S3.
- **Palette RAM:** inferred 32×6 distributed RAM, with one write/read port and one read port.

## Test plan
- **Priority.** Write pal[0x05]=0x16 and pal[0x11]=0x2A. Drive bg=0x5, spr=0x01 at x=100.
  - `spr[4]=0`: 3 cycles later `o_pixel` = ROM[0x2A].
  - `spr[4]=1`: `o_pixel` = ROM[0x16].
- **Mirroring.** Write 0x10←0x21, then read 0x00 → `o_pal_rdata` = 0x21. Both layers transparent → `o_pixel` = ROM[0x21].
- **Clipping and sprite-0.** bg=0x1, spr=0x01, `i_spr0`=1, `i_bg_clip`=1.
  - x=5: `o_spr0_hit` stays 0 and the pixel is the sprite colour.
  - x=8: hit = 1 next cycle.
  - x=255 with no clip: no hit.
- **Hit clear collision.** Hit condition and `i_exiting_vblank` in the same cycle → `o_spr0_hit` = 0.
- **Grayscale.** pal[0x01]=0x2C, bg=0x1, `i_gray`=1 → `o_pixel` = ROM[0x20].
- **Reset/ce.** Assert `i_rst` during a stream of `i_active` → all outputs 0. After release, `o_valid` returns exactly 3 cycles after `i_active`. `i_ce` low for 4 cycles → outputs frozen.
